// File: rtl/cpu_sequencer.sv
// Cycle sequencer for the Nandy CPU: fetches instruction bytes over a ready
// handshake, then steps through one or two execute cycles per instruction.
module cpu_sequencer #(
  parameter int unsigned WAIT_LIMIT = 15,
  parameter int unsigned CNT_W      = 16,
  parameter logic [7:0]  RESET_INST = 8'h00
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             step_mode,
  input  logic [7:0]       mem_rdata,
  input  logic             mem_ready,
  input  logic             mc,
  input  logic             mem_op,
  input  logic             nsig_halt,
  output logic [7:0]       inst,
  output logic             cycle,
  output logic             ncycle,
  output logic             fetch_req,
  output logic             data_req,
  output logic             pc_inc,
  output logic             exec_en,
  output logic             halted,
  output logic             bus_err,
  output logic [CNT_W-1:0] retired
);

  localparam int unsigned WAIT_W   = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam int unsigned WAIT_MAX = (WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0;
  localparam bit          WAIT_ON  = (WAIT_LIMIT > 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC0 = 3'd2,
    S_EXEC1 = 3'd3,
    S_HALT  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        inst_q, inst_d;
  logic              bus_err_q, bus_err_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic accept_c, stall_c, timeout_c, retire_c;

  // Handshake and retire qualifiers shared by next-state and output logic
  always_comb begin
    accept_c  = (state_q == S_FETCH) && mem_ready;
    stall_c   = ((state_q == S_FETCH) && !mem_ready) ||
                ((state_q == S_EXEC1) && mem_op && !mem_ready);
    timeout_c = WAIT_ON && stall_c && (wait_q == WAIT_W'(WAIT_MAX));
    retire_c  = ((state_q == S_EXEC0) && !mc) ||
                ((state_q == S_EXEC1) && (!mem_op || mem_ready));
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      inst_q    <= RESET_INST;
      bus_err_q <= 1'b0;
      retired_q <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      inst_q    <= inst_d;
      bus_err_q <= bus_err_d;
      retired_q <= retired_d;
      wait_q    <= wait_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    inst_d    = inst_q;
    bus_err_d = bus_err_q;
    retired_d = retired_q;
    wait_d    = '0;

    unique case (state_q)
      S_IDLE:  if (run) state_d = S_FETCH;
      S_FETCH: begin
        if (accept_c) begin
          inst_d  = mem_rdata;
          state_d = S_EXEC0;
        end else if (timeout_c) begin
          bus_err_d = 1'b1;
          state_d   = S_HALT;
        end
      end
      S_EXEC0: if (mc) state_d = S_EXEC1;
      S_EXEC1: begin
        if (timeout_c) begin
          bus_err_d = 1'b1;
          state_d   = S_HALT;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    // Halt request wins over single-step at retire
    if (retire_c) begin
      retired_d = retired_q + CNT_W'(1);
      if (!nsig_halt)     state_d = S_HALT;
      else if (step_mode) state_d = S_IDLE;
      else                state_d = S_FETCH;
    end

    // Stalls hold the state, so counting here only ever spans one state
    if (WAIT_ON && stall_c && !timeout_c) wait_d = wait_q + WAIT_W'(1);
  end

  // Output decode
  always_comb begin
    cycle     = 1'b0;
    fetch_req = 1'b0;
    data_req  = 1'b0;
    pc_inc    = 1'b0;
    exec_en   = 1'b0;
    halted    = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        fetch_req = 1'b1;
        pc_inc    = accept_c;
      end
      S_EXEC0: exec_en = 1'b1;
      S_EXEC1: begin
        cycle    = 1'b1;
        data_req = mem_op;
        exec_en  = retire_c;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign ncycle  = ~cycle;
  assign inst    = inst_q;
  assign bus_err = bus_err_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: per-cycle vector table plus hand-written
// sequences for counter wrap and halt-over-step priority.
module tb_cpu_sequencer;

  localparam int unsigned CNT_W = 4;

  typedef struct packed {
    logic       rst_n;
    logic       run;
    logic       step;
    logic [7:0] rdata;
    logic       rdy;
    logic       mc;
    logic       mop;
    logic       nh;
  } in_t;

  typedef struct packed {
    logic [7:0]       inst;
    logic             cyc;
    logic             ncyc;
    logic             freq;
    logic             dreq;
    logic             pci;
    logic             exe;
    logic             hlt;
    logic             err;
    logic [CNT_W-1:0] ret;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n, run, step_mode, mem_ready, mc, mem_op, nsig_halt;
  logic [7:0]       mem_rdata;
  logic [7:0]       inst;
  logic             cycle, ncycle, fetch_req, data_req, pc_inc, exec_en, halted, bus_err;
  logic [CNT_W-1:0] retired;

  int errors = 0;
  int checks = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  cpu_sequencer #(.WAIT_LIMIT(15), .CNT_W(CNT_W), .RESET_INST(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step_mode(step_mode),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mc(mc), .mem_op(mem_op),
    .nsig_halt(nsig_halt), .inst(inst), .cycle(cycle), .ncycle(ncycle),
    .fetch_req(fetch_req), .data_req(data_req), .pc_inc(pc_inc),
    .exec_en(exec_en), .halted(halted), .bus_err(bus_err), .retired(retired)
  );

  function automatic in_t mi(input logic r, input logic ru, input logic st,
                             input logic [7:0] d, input logic rd, input logic m,
                             input logic mo, input logic n);
    in_t t;
    t.rst_n = r; t.run = ru; t.step = st; t.rdata = d;
    t.rdy = rd; t.mc = m; t.mop = mo; t.nh = n;
    return t;
  endfunction

  function automatic out_t mo_(input logic [7:0] in_v, input logic c, input logic f,
                               input logic d, input logic p, input logic e,
                               input logic h, input logic er, input int r);
    out_t t;
    t.inst = in_v; t.cyc = c; t.ncyc = ~c; t.freq = f; t.dreq = d;
    t.pci = p; t.exe = e; t.hlt = h; t.err = er; t.ret = CNT_W'(r);
    return t;
  endfunction

  task automatic add(input in_t i, input out_t o);
    vec_t v;
    v.i = i; v.o = o;
    vecs.push_back(v);
  endtask

  task automatic drive(input in_t i);
    @(negedge clk);
    rst_n = i.rst_n; run = i.run; step_mode = i.step; mem_rdata = i.rdata;
    mem_ready = i.rdy; mc = i.mc; mem_op = i.mop; nsig_halt = i.nh;
    #1;
  endtask

  function automatic out_t sample();
    out_t t;
    t.inst = inst; t.cyc = cycle; t.ncyc = ncycle; t.freq = fetch_req;
    t.dreq = data_req; t.pci = pc_inc; t.exe = exec_en; t.hlt = halted;
    t.err = bus_err; t.ret = retired;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  initial begin
    in_t  rs, i;
    out_t z, o;
    int   pulses;
    bit   seen;

    rst_n = 1'b0; run = 1'b0; step_mode = 1'b0; mem_rdata = 8'h00;
    mem_ready = 1'b0; mc = 1'b0; mem_op = 1'b0; nsig_halt = 1'b1;

    rs = mi(0, 0, 0, 8'h00, 0, 0, 0, 1);
    z  = mo_(8'h00, 0, 0, 0, 0, 0, 0, 0, 0);

    // Three 1-cycle instructions back to back
    add(rs, z);
    i = mi(1, 1, 0, 8'h41, 1, 0, 0, 1);
    add(i, z);
    add(i, mo_(8'h00, 0, 1, 0, 1, 0, 0, 0, 0));
    add(i, mo_(8'h41, 0, 0, 0, 0, 1, 0, 0, 0));
    add(i, mo_(8'h41, 0, 1, 0, 1, 0, 0, 0, 1));
    add(i, mo_(8'h41, 0, 0, 0, 0, 1, 0, 0, 1));
    add(i, mo_(8'h41, 0, 1, 0, 1, 0, 0, 0, 2));
    add(i, mo_(8'h41, 0, 0, 0, 0, 1, 0, 0, 2));
    add(mi(1, 1, 0, 8'h41, 0, 0, 0, 1), mo_(8'h41, 0, 1, 0, 0, 0, 0, 0, 3));
    // Two-cycle memory instruction with 3-clock data stall
    add(mi(1, 1, 0, 8'h85, 1, 1, 1, 1), mo_(8'h41, 0, 1, 0, 1, 0, 0, 0, 3));
    i = mi(1, 1, 0, 8'h85, 0, 1, 1, 1);
    add(i, mo_(8'h85, 0, 0, 0, 0, 1, 0, 0, 3));
    for (int k = 0; k < 3; k++) add(i, mo_(8'h85, 1, 0, 1, 0, 0, 0, 0, 3));
    add(mi(1, 1, 0, 8'h85, 1, 1, 1, 1), mo_(8'h85, 1, 0, 1, 0, 1, 0, 0, 3));
    // Halting instruction commits, counts, then stops fetching
    add(mi(1, 1, 0, 8'h18, 1, 0, 0, 0), mo_(8'h85, 0, 1, 0, 1, 0, 0, 0, 4));
    add(mi(1, 1, 0, 8'h18, 1, 0, 0, 0), mo_(8'h18, 0, 0, 0, 0, 1, 0, 0, 4));
    add(mi(1, 1, 0, 8'h18, 1, 0, 0, 1), mo_(8'h18, 0, 0, 0, 0, 0, 1, 0, 5));
    add(mi(1, 1, 0, 8'h18, 1, 0, 0, 1), mo_(8'h18, 0, 0, 0, 0, 0, 1, 0, 5));
    // Fetch timeout after exactly 15 stall clocks
    add(rs, z);
    i = mi(1, 1, 0, 8'h00, 0, 0, 0, 1);
    add(i, z);
    for (int k = 0; k < 15; k++) add(i, mo_(8'h00, 0, 1, 0, 0, 0, 0, 0, 0));
    add(i, mo_(8'h00, 0, 0, 0, 0, 0, 1, 1, 0));
    add(i, mo_(8'h00, 0, 0, 0, 0, 0, 1, 1, 0));
    // Single-step: one instruction per run pulse
    add(rs, z);
    add(mi(1, 1, 1, 8'h41, 1, 0, 0, 1), z);
    i = mi(1, 0, 1, 8'h41, 1, 0, 0, 1);
    add(i, mo_(8'h00, 0, 1, 0, 1, 0, 0, 0, 0));
    add(i, mo_(8'h41, 0, 0, 0, 0, 1, 0, 0, 0));
    add(i, mo_(8'h41, 0, 0, 0, 0, 0, 0, 0, 1));
    add(i, mo_(8'h41, 0, 0, 0, 0, 0, 0, 0, 1));
    add(mi(1, 1, 1, 8'h41, 1, 0, 0, 1), mo_(8'h41, 0, 0, 0, 0, 0, 0, 0, 1));
    add(i, mo_(8'h41, 0, 1, 0, 1, 0, 0, 0, 1));
    add(i, mo_(8'h41, 0, 0, 0, 0, 1, 0, 0, 1));
    add(i, mo_(8'h41, 0, 0, 0, 0, 0, 0, 0, 2));
    add(i, mo_(8'h41, 0, 0, 0, 0, 0, 0, 0, 2));
    // Reset asserted mid-EXEC1 takes effect immediately, nothing commits
    add(mi(1, 1, 0, 8'h85, 1, 1, 1, 1), mo_(8'h41, 0, 0, 0, 0, 0, 0, 0, 2));
    add(mi(1, 1, 0, 8'h85, 1, 1, 1, 1), mo_(8'h41, 0, 1, 0, 1, 0, 0, 0, 2));
    add(mi(1, 1, 0, 8'h85, 0, 1, 1, 1), mo_(8'h85, 0, 0, 0, 0, 1, 0, 0, 2));
    add(mi(1, 1, 0, 8'h85, 0, 1, 1, 1), mo_(8'h85, 1, 0, 1, 0, 0, 0, 0, 2));
    add(mi(0, 1, 0, 8'h85, 1, 1, 1, 1), z);

    foreach (vecs[k]) begin
      drive(vecs[k].i);
      o = sample();
      checks++;
      if (o !== vecs[k].o) begin
        errors++;
        $display("FAIL vec%0d: got %h expected %h", k, o, vecs[k].o);
      end
    end

    // Retired counter wraps 15 -> 0 on the 16th instruction
    drive(mi(1, 1, 0, 8'h41, 1, 0, 0, 1));
    pulses = 0;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      if (exec_en) begin
        pulses++;
        if (pulses == 16) seen = 1'b1;
      end
      if (!seen) drive(mi(1, 1, 0, 8'h41, 1, 0, 0, 1));
    end
    check("wrap_reached", 32'(seen), 32'd1);
    check("ret_before_wrap", 32'(retired), 32'd15);
    drive(mi(1, 1, 0, 8'h41, 0, 0, 0, 1));
    check("ret_after_wrap", 32'(retired), 32'd0);
    check("fetch_after_wrap", 32'(fetch_req), 32'd1);

    // Halt wins over step_mode at retire
    drive(rs);
    drive(mi(1, 1, 1, 8'h18, 1, 0, 0, 0));
    drive(mi(1, 1, 1, 8'h18, 1, 0, 0, 0));
    drive(mi(1, 1, 1, 8'h18, 1, 0, 0, 0));
    check("halt_step_exec", 32'(exec_en), 32'd1);
    drive(mi(1, 1, 1, 8'h18, 1, 0, 0, 0));
    check("halt_step_halted", 32'(halted), 32'd1);
    check("halt_step_ret", 32'(retired), 32'd1);
    drive(mi(1, 1, 1, 8'h18, 1, 0, 0, 0));
    check("halt_step_nofetch", 32'(fetch_req), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
